leb128_u32_stream: RTL and testbench

- Streaming front-end for the combinational unpack_u32 LEB128 decoder.
- Accepts a byte stream on a valid/ready interface and buffers up to 5 bytes in a window.
- Presents the window to unpack_u32, registers each decoded u32 with its byte length on a valid/ready output, then retires exactly that many bytes from the window.
- Sits between a byte-oriented parser (e.g. a wasm section reader) and consumers of u32 fields.

---
 rtl/leb128_pkg.sv | 21 ++
 rtl/unpack_u32.sv | 39 +++
 rtl/leb128_u32_stream.sv | 97 +++++++++
 tb/tb_leb128_u32_stream.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leb128_pkg.sv
// Shared constants, window type and terminator scan for the LEB128 u32 path.
package leb128_pkg;

  localparam int LEB_MAX_BYTES = 5;
  localparam int LEB_CONT_BIT  = 7;

  // Byte window, index 0 is the oldest byte.
  typedef logic [LEB_MAX_BYTES-1:0][7:0] win_t;

  // Index of the first byte among slots 0..n-1 whose continuation bit is
  // clear. Returns LEB_MAX_BYTES when none of those slots terminates.
  function automatic logic [2:0] first_term_idx(input win_t w, input logic [2:0] n);
    logic [2:0] idx;
    idx = 3'(LEB_MAX_BYTES);
    for (int k = LEB_MAX_BYTES - 1; k >= 0; k--) begin
      if (3'(k) < n && !w[k][LEB_CONT_BIT]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/unpack_u32.sv
// Combinational LEB128 u32 decoder over a 5-byte window.
// Ports:
//   b0..b4 : window bytes, b0 first on the wire
//   o      : decoded value, low 32 bits of the 7-bit-group payload
//   len    : bytes used, 1..5 (5 when no byte terminates)
module unpack_u32
  import leb128_pkg::*;
(
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  logic [7:0]  b4,
  output logic [31:0] o,
  output logic [2:0]  len
);

  win_t        w;
  logic [2:0]  idx;
  logic [34:0] p;
  logic [2:0]  unused_hi;

  assign w = {b4, b3, b2, b1, b0};
  assign idx = first_term_idx(w, 3'(LEB_MAX_BYTES));

  // Only groups up to and including the terminator contribute.
  always_comb begin
    p = '0;
    for (int k = 0; k < LEB_MAX_BYTES; k++) begin
      if (3'(k) <= idx) p[k*7 +: 7] = w[k][6:0];
    end
  end

  // Payload bits above 31 (from the fifth byte) are dropped.
  assign o         = p[31:0];
  assign unused_hi = p[34:32];
  assign len       = (idx == 3'(LEB_MAX_BYTES)) ? 3'(LEB_MAX_BYTES) : idx + 3'd1;

endmodule

// File: rtl/leb128_u32_stream.sv
// Streaming LEB128 u32 decoder: buffers input bytes in a 5-byte window,
// decodes each complete value through unpack_u32, registers it on a
// valid/ready output and retires the consumed bytes.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_data/valid/ready : byte input stream
//   out_data/len/err    : decoded value, bytes consumed, overlong flag
//   out_valid/ready     : output handshake
//   count               : values handed off, wraps
module leb128_u32_stream
  import leb128_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_len,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  win_t        win;
  logic [2:0]  cnt;
  logic [2:0]  term_idx;
  logic        found;
  logic        full;
  logic        complete;
  logic        err;
  logic [2:0]  len;
  logic        load;
  logic [31:0] dec_o;
  logic [2:0]  dec_len;

  unpack_u32 u_unpack (
    .b0  (win[0]),
    .b1  (win[1]),
    .b2  (win[2]),
    .b3  (win[3]),
    .b4  (win[4]),
    .o   (dec_o),
    .len (dec_len)
  );

  always_comb begin
    term_idx = first_term_idx(win, cnt);
    found    = (term_idx != 3'(LEB_MAX_BYTES));
    full     = (cnt == 3'(LEB_MAX_BYTES));
    complete = found || full;
    err      = !found && full;
    len      = found ? term_idx + 3'd1 : 3'(LEB_MAX_BYTES);
    in_ready = !complete && !full;
    load     = complete && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_len   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      // Load and input are mutually exclusive since in_ready is low while complete.
      if (load) begin
        win       <= win >> {len, 3'b000};
        cnt       <= cnt - len;
        out_data  <= dec_o;
        out_len   <= len;
        out_err   <= err;
        out_valid <= 1'b1;
      end else begin
        if (in_valid && in_ready) begin
          win[cnt] <= in_data;
          cnt      <= cnt + 3'd1;
        end
        if (out_ready) out_valid <= 1'b0;
      end
      if (out_valid && out_ready) count <= count + 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && complete && !err)
      assert (dec_len == len) else $error("unpack_u32 length disagrees with window scan");
  end
`endif

endmodule

// File: tb/tb_leb128_u32_stream.sv
module tb_leb128_u32_stream;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  l;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_len;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] count;

  int   n_checks = 0;
  int   n_fail = 0;
  int   xfer_cnt = 0;
  int   ready_mode = 0;  // 0: hold low, 1: hold high, 2: random
  exp_t exp_q[$];
  logic [7:0] enc_q[$];

  logic        prev_hold = 1'b0;
  logic [31:0] prev_d;
  logic [2:0]  prev_l;
  logic        prev_e;

  leb128_u32_stream #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference encoder: 7-bit groups, low first, bit7 set on all but the last.
  function automatic void encode_to(input logic [31:0] v);
    logic [31:0] r;
    logic [7:0]  b;
    enc_q.delete();
    r = v;
    do begin
      b = {1'b0, r[6:0]};
      r = r >> 7;
      if (r != 0) b[7] = 1'b1;
      enc_q.push_back(b);
    end while (r != 0);
  endfunction

  always @(posedge clk) begin
    #2;
    if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (ready_mode == 1);
  end

  // Compare process: checks each handed-off value, hold stability and count.
  always @(negedge clk) begin
    if (reset) begin
      xfer_cnt  = 0;
      prev_hold = 1'b0;
    end else begin
      chk("count", {16'b0, count}, {16'b0, 16'(xfer_cnt)});
      if (prev_hold) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_data", out_data, prev_d);
        chk("hold_len_err", {28'b0, out_len, out_err}, {28'b0, prev_l, prev_e});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_data, 32'hxxxx_xxxx);
        end else begin
          chk("out_data", out_data, exp_q[0].d);
          chk("out_len", {29'b0, out_len}, {29'b0, exp_q[0].l});
          chk("out_err", {31'b0, out_err}, {31'b0, exp_q[0].e});
          void'(exp_q.pop_front());
        end
        xfer_cnt++;
      end
      prev_hold = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_len;
      prev_e = out_err;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drives one byte; returns #1 after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (gap) @(posedge clk);
    #0;
    in_data = b;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_value(input logic [31:0] v, input int max_gap);
    exp_t e;
    logic [7:0] bytes[$];
    encode_to(v);
    bytes = enc_q;
    e.d = v;
    e.l = 3'(bytes.size());
    e.e = 1'b0;
    exp_q.push_back(e);
    foreach (bytes[i]) send_byte(bytes[i], max_gap);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [2:0] l, input logic e);
    exp_t x;
    x.d = d; x.l = l; x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v;
    int n_rand;

    // Pin the reference encoder with hand-computed encodings.
    encode_to(32'd624485);
    chk("enc_624485_len", 32'(enc_q.size()), 32'd3);
    chk("enc_624485", {8'h0, enc_q[0], enc_q[1], enc_q[2]}, 32'h00E58E26);
    encode_to(32'd128);
    chk("enc_128", {16'h0, enc_q[0], enc_q[1]}, 32'h00008001);
    encode_to(32'hFFFFFFFF);
    chk("enc_max_len", 32'(enc_q.size()), 32'd5);
    chk("enc_max_last", {24'h0, enc_q[4]}, 32'h0000000F);

    // Reset state
    ready_mode = 1;
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_len_err", {28'b0, out_len, out_err}, 32'd0);
    chk("rst_count", {16'b0, count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single-byte values and one-cycle load latency
    push_exp(32'd0, 3'd1, 1'b0);
    send_byte(8'h00, 0);
    @(negedge clk);
    chk("lat0_valid_n", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat0_valid_n1", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    push_exp(32'd42, 3'd1, 1'b0);
    send_byte(8'h2A, 0);
    @(negedge clk);
    chk("lat42_valid_n", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat42_valid_n1", {31'b0, out_valid}, 32'd1);
    chk("lat42_data", out_data, 32'd42);
    wait_idle();
    chk("t1_count", {16'b0, count}, 32'd2);

    // Three-byte value
    do_reset();
    push_exp(32'd624485, 3'd3, 1'b0);
    send_byte(8'hE5, 0);
    send_byte(8'h8E, 0);
    send_byte(8'h26, 0);
    @(negedge clk);
    chk("t2_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("t2_in_ready_back", {31'b0, in_ready}, 32'd1);
    chk("t2_data", out_data, 32'd624485);
    chk("t2_len", {29'b0, out_len}, 32'd3);
    wait_idle();

    // Backpressure with a second value buffered behind the held output
    do_reset();
    ready_mode = 0;
    push_exp(32'd1, 3'd1, 1'b0);
    push_exp(32'd128, 3'd2, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h80, 0);
    send_byte(8'h01, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t3_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_hold_data", out_data, 32'd1);
    chk("t3_hold_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    ready_mode = 1;
    push_exp(32'd5, 3'd1, 1'b0);
    send_byte(8'h05, 0);
    wait_idle();
    chk("t3_count", {16'b0, count}, 32'd3);

    // Overlong five-byte encoding, then recovery
    do_reset();
    push_exp(32'hFFFFFFFF, 3'd5, 1'b1);
    repeat (5) send_byte(8'hFF, 0);
    push_exp(32'd7, 3'd1, 1'b0);
    send_byte(8'h07, 0);
    wait_idle();
    chk("t4_count", {16'b0, count}, 32'd2);

    // Reset mid-value discards the partial bytes
    do_reset();
    send_byte(8'h80, 0);
    send_byte(8'h80, 0);
    do_reset();
    push_exp(32'd3, 3'd1, 1'b0);
    send_byte(8'h03, 0);
    wait_idle();
    chk("t5_count", {16'b0, count}, 32'd1);

    // Random values with random input gaps and output backpressure
    do_reset();
    ready_mode = 2;
    n_rand = 200;
    for (int i = 0; i < n_rand; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if (i == 0) v = 32'hFFFFFFFF;
      if (i == 1) v = 32'h0;
      send_value(v, 2);
    end
    ready_mode = 1;
    wait_idle();
    chk("rand_count", {16'b0, count}, 32'(n_rand));
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
